// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: parametrised data/parity/stop framing, parity, framing
// and break detection, and a ready/valid holding register with overrun reporting.
module uart_rx_cfg #(
  parameter int CLOCKS_PER_BAUD = 6,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 break_o
);

  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic PAR_EXP = (PARITY == 1) ? 1'b1 : 1'b0;
  localparam logic HAS_PAR = (PARITY != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, data_q, data_d;
  logic                 par_bit_q, par_bit_d, par_bad_q, par_bad_d;
  logic                 frame_bad_q, frame_bad_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                 ovr_q, ovr_d, brk_q, brk_d;
  logic                 rx, sample, stop_bad, is_break;

  assign rx     = rx_sync_q;
  assign sample = (cnt_q == '0);

  always_comb begin
    rx_meta_d   = rx_i;
    rx_sync_d   = rx_meta_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    par_bit_d   = par_bit_q;
    par_bad_d   = par_bad_q;
    frame_bad_d = frame_bad_q;
    data_d      = data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    valid_d     = valid_q & ~ready_i;
    ovr_d       = 1'b0;
    brk_d       = 1'b0;
    stop_bad    = frame_bad_q | ~rx;
    is_break    = stop_bad && (shreg_q == '0) && (!HAS_PAR || !par_bit_q);

    if ((state_q == START || state_q == DATA || state_q == PAR || state_q == STOP) && !sample)
      cnt_d = cnt_q - CW'(1);

    case (state_q)
      IDLE: begin
        if (!rx) begin
          state_d     = START;
          cnt_d       = HALF;
          par_bad_d   = 1'b0;
          frame_bad_d = 1'b0;
        end
      end
      START: begin
        if (sample) begin
          if (rx) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = FULL;
            idx_d   = 4'd0;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
          cnt_d   = FULL;
          if (idx_q == LAST_DATA) begin
            idx_d   = 4'd0;
            state_d = HAS_PAR ? PAR : STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (sample) begin
          par_bit_d = rx;
          par_bad_d = ((^shreg_q) ^ rx) != PAR_EXP;
          state_d   = STOP;
          cnt_d     = FULL;
          idx_d     = 4'd0;
        end
      end
      STOP: begin
        if (sample) begin
          cnt_d       = FULL;
          frame_bad_d = stop_bad;
          if (idx_q == LAST_STOP) begin
            idx_d = 4'd0;
            if (is_break) begin
              brk_d   = 1'b1;
              state_d = WAIT_HIGH;
            end else begin
              // A completed frame replaces the held one only if it has been or is being taken.
              if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                perr_d  = par_bad_q;
                ferr_d  = stop_bad;
                valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
              state_d = rx ? IDLE : WAIT_HIGH;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      par_bad_q   <= 1'b0;
      frame_bad_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      par_bit_q   <= par_bit_d;
      par_bad_q   <= par_bad_d;
      frame_bad_q <= frame_bad_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
      brk_q       <= brk_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign break_o      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 7E1 and 8N2 instances driven bit by bit.
module tb_uart_rx_cfg;
  localparam int CPB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
  logic rdy_a = 1'b1, rdy_b = 1'b1, rdy_c = 1'b1;

  logic [7:0] data_a, data_c;
  logic [6:0] data_b;
  logic valid_a, par_a, frm_a, ovr_a, brk_a;
  logic valid_b, par_b, frm_b, ovr_b, brk_b;
  logic valid_c, par_c, frm_c, ovr_c, brk_c;

  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clock(clk), .reset(reset), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a),
    .ready_i(rdy_a), .parity_err_o(par_a), .frame_err_o(frm_a), .overrun_o(ovr_a),
    .break_o(brk_a));

  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clock(clk), .reset(reset), .rx_i(rx_b), .data_o(data_b), .valid_o(valid_b),
    .ready_i(rdy_b), .parity_err_o(par_b), .frame_err_o(frm_b), .overrun_o(ovr_b),
    .break_o(brk_b));

  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clock(clk), .reset(reset), .rx_i(rx_c), .data_o(data_c), .valid_o(valid_c),
    .ready_i(rdy_c), .parity_err_o(par_c), .frame_err_o(frm_c), .overrun_o(ovr_c),
    .break_o(brk_c));

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Accepted frames are queued as {parity_err, frame_err, 9-bit zero-extended data}.
  logic [10:0] q_a[$], q_b[$], q_c[$];
  int vrise_a = 0, rise_a = 0, rise_c = 0, ovr_n = 0, brk_n = 0;
  logic vprev_a = 1'b0, vprev_c = 1'b0;

  always @(negedge clk) begin
    if (valid_a && !vprev_a) begin
      vrise_a <= vrise_a + 1;
      rise_a  <= cyc;
    end
    if (valid_c && !vprev_c) rise_c <= cyc;
    vprev_a <= valid_a;
    vprev_c <= valid_c;
    if (ovr_a) ovr_n <= ovr_n + 1;
    if (brk_a) brk_n <= brk_n + 1;
    if (valid_a && rdy_a) q_a.push_back({par_a, frm_a, 1'b0, data_a});
    if (valid_b && rdy_b) q_b.push_back({par_b, frm_b, 2'b00, data_b});
    if (valid_c && rdy_c) q_c.push_back({par_c, frm_c, 1'b0, data_c});
  end

  function automatic logic [9:0] fa(input logic [7:0] d, input logic stp);
    return {stp, d, 1'b0};
  endfunction

  function automatic logic [9:0] fb(input logic [6:0] d, input logic par, input logic stp);
    return {stp, par, d, 1'b0};
  endfunction

  function automatic logic [10:0] fc(input logic [7:0] d, input logic s1, input logic s2);
    return {s2, s1, d, 1'b0};
  endfunction

  task automatic set_rx(input int which, input logic v);
    case (which)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives n bits LSB first, CPB clocks each, then returns the line to idle high.
  task automatic send(input int which, input logic [31:0] bits, input int n, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      set_rx(which, bits[i]);
      repeat (CPB) @(posedge clk);
      #1;
    end
    set_rx(which, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if ({valid_a, valid_b, valid_c} !== 3'b000) $display("FAIL reset_valid got %b want 000", {valid_a, valid_b, valid_c}); else pass_cnt++;
    total_cnt++; if (data_a !== 8'h00) $display("FAIL reset_data_a got %h want 00", data_a); else pass_cnt++;
    total_cnt++; if ({data_b, data_c} !== 15'h0) $display("FAIL reset_data_bc got %h want 0", {data_b, data_c}); else pass_cnt++;
    total_cnt++; if ({par_a, frm_a, ovr_a, brk_a} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {par_a, frm_a, ovr_a, brk_a}); else pass_cnt++;
    reset = 1'b1;
    idle(4);
  endtask

  task automatic test_basic();
    int t0;
    logic [10:0] e;
    q_a.delete();
    send(0, 32'(fa(8'hA5, 1'b1)), 10, t0);
    idle(3);
    total_cnt++; if (rise_a - t0 !== 60) $display("FAIL basic_latency got %0d want 60", rise_a - t0); else pass_cnt++;
    total_cnt++; if (q_a.size() !== 1) $display("FAIL basic_count got %0d want 1", q_a.size()); else pass_cnt++;
    e = (q_a.size() > 0) ? q_a.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h0A5}) $display("FAIL basic_data got %h want %h", e, {2'b00, 9'h0A5}); else pass_cnt++;
    total_cnt++; if (valid_a !== 1'b0) $display("FAIL basic_valid_clear got %b want 0", valid_a); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [10:0] e;
    q_a.delete();
    send(0, 32'({fa(8'h81, 1'b1), fa(8'h3C, 1'b1)}), 20, t0);
    idle(12);
    total_cnt++; if (q_a.size() !== 2) $display("FAIL b2b_count got %0d want 2", q_a.size()); else pass_cnt++;
    e = (q_a.size() > 0) ? q_a.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h03C}) $display("FAIL b2b_first got %h want %h", e, {2'b00, 9'h03C}); else pass_cnt++;
    e = (q_a.size() > 0) ? q_a.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h081}) $display("FAIL b2b_second got %h want %h", e, {2'b00, 9'h081}); else pass_cnt++;
  endtask

  task automatic test_parity();
    int t0;
    logic [10:0] e;
    q_b.delete();
    // 0x41 has two ones, so even parity wants a 0 parity bit.
    send(1, 32'({fb(7'h41, 1'b1, 1'b1), fb(7'h41, 1'b0, 1'b1)}), 20, t0);
    idle(12);
    total_cnt++; if (q_b.size() !== 2) $display("FAIL parity_count got %0d want 2", q_b.size()); else pass_cnt++;
    e = (q_b.size() > 0) ? q_b.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h041}) $display("FAIL parity_good got %h want %h", e, {2'b00, 9'h041}); else pass_cnt++;
    e = (q_b.size() > 0) ? q_b.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b10, 9'h041}) $display("FAIL parity_bad got %h want %h", e, {2'b10, 9'h041}); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int t0;
    int b0;
    logic [10:0] e;
    q_a.delete();
    b0 = brk_n;
    send(0, 32'(fa(8'h55, 1'b0)), 10, t0);
    idle(2 * CPB);
    send(0, 32'(fa(8'h12, 1'b1)), 10, t0);
    idle(12);
    total_cnt++; if (q_a.size() !== 2) $display("FAIL frame_count got %0d want 2", q_a.size()); else pass_cnt++;
    e = (q_a.size() > 0) ? q_a.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b01, 9'h055}) $display("FAIL frame_err got %h want %h", e, {2'b01, 9'h055}); else pass_cnt++;
    e = (q_a.size() > 0) ? q_a.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h012}) $display("FAIL frame_next got %h want %h", e, {2'b00, 9'h012}); else pass_cnt++;
    total_cnt++; if (brk_n !== b0) $display("FAIL frame_no_break got %0d want %0d", brk_n, b0); else pass_cnt++;
  endtask

  task automatic test_break();
    int t0;
    int b0;
    int v0;
    logic [10:0] e;
    q_a.delete();
    b0 = brk_n;
    v0 = vrise_a;
    @(posedge clk);
    #1;
    rx_a = 1'b0;
    repeat (20 * CPB) @(posedge clk);
    #1;
    rx_a = 1'b1;
    idle(2 * CPB);
    total_cnt++; if (brk_n - b0 !== 1) $display("FAIL break_pulses got %0d want 1", brk_n - b0); else pass_cnt++;
    total_cnt++; if (vrise_a !== v0) $display("FAIL break_no_valid got %0d want %0d", vrise_a, v0); else pass_cnt++;
    send(0, 32'(fa(8'h7E, 1'b1)), 10, t0);
    idle(12);
    total_cnt++; if (q_a.size() !== 1) $display("FAIL break_after_count got %0d want 1", q_a.size()); else pass_cnt++;
    e = (q_a.size() > 0) ? q_a.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h07E}) $display("FAIL break_after_data got %h want %h", e, {2'b00, 9'h07E}); else pass_cnt++;
  endtask

  task automatic test_overrun();
    int t0;
    int o0;
    logic [10:0] e;
    q_a.delete();
    o0 = ovr_n;
    rdy_a = 1'b0;
    send(0, 32'({fa(8'h22, 1'b1), fa(8'h11, 1'b1)}), 20, t0);
    idle(12);
    total_cnt++; if (valid_a !== 1'b1) $display("FAIL ovr_valid_held got %b want 1", valid_a); else pass_cnt++;
    total_cnt++; if (data_a !== 8'h11) $display("FAIL ovr_data_held got %h want 11", data_a); else pass_cnt++;
    total_cnt++; if (ovr_n - o0 !== 1) $display("FAIL ovr_pulses got %0d want 1", ovr_n - o0); else pass_cnt++;
    total_cnt++; if ({par_a, frm_a} !== 2'b00) $display("FAIL ovr_flags got %b want 00", {par_a, frm_a}); else pass_cnt++;
    rdy_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total_cnt++; if (valid_a !== 1'b0) $display("FAIL ovr_valid_fall got %b want 0", valid_a); else pass_cnt++;
    e = (q_a.size() > 0) ? q_a.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h011}) $display("FAIL ovr_accepted got %h want %h", e, {2'b00, 9'h011}); else pass_cnt++;
    idle(2);
  endtask

  task automatic test_glitch_reset();
    int t0;
    int v0;
    logic [10:0] e;
    q_a.delete();
    v0 = vrise_a;
    @(posedge clk);
    #1;
    rx_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx_a = 1'b1;
    idle(5 * CPB);
    total_cnt++; if (vrise_a !== v0) $display("FAIL glitch_no_valid got %0d want %0d", vrise_a, v0); else pass_cnt++;
    // Start + three data bits, then reset lands while the receiver is in DATA.
    send(0, 32'(fa(8'hC3, 1'b1)), 4, t0);
    reset = 1'b0;
    #1;
    total_cnt++; if (data_a !== 8'h00) $display("FAIL rst_mid_data_a got %h want 00", data_a); else pass_cnt++;
    total_cnt++; if (data_b !== 7'h00) $display("FAIL rst_mid_data_b got %h want 00", data_b); else pass_cnt++;
    total_cnt++; if (valid_a !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", valid_a); else pass_cnt++;
    idle(3);
    reset = 1'b1;
    idle(10 * CPB);
    total_cnt++; if (vrise_a !== v0) $display("FAIL rst_no_frame got %0d want %0d", vrise_a, v0); else pass_cnt++;
    send(0, 32'(fa(8'hC3, 1'b1)), 10, t0);
    idle(12);
    total_cnt++; if (q_a.size() !== 1) $display("FAIL rst_after_count got %0d want 1", q_a.size()); else pass_cnt++;
    e = (q_a.size() > 0) ? q_a.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h0C3}) $display("FAIL rst_after_data got %h want %h", e, {2'b00, 9'h0C3}); else pass_cnt++;
  endtask

  task automatic test_stop2();
    int t0;
    logic [10:0] e;
    q_c.delete();
    send(2, 32'({fc(8'h5A, 1'b1, 1'b0), fc(8'h96, 1'b1, 1'b1)}), 22, t0);
    idle(12);
    total_cnt++; if (rise_c - t0 !== 132) $display("FAIL stop2_latency got %0d want 132", rise_c - t0); else pass_cnt++;
    total_cnt++; if (q_c.size() !== 2) $display("FAIL stop2_count got %0d want 2", q_c.size()); else pass_cnt++;
    e = (q_c.size() > 0) ? q_c.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b00, 9'h096}) $display("FAIL stop2_clean got %h want %h", e, {2'b00, 9'h096}); else pass_cnt++;
    e = (q_c.size() > 0) ? q_c.pop_front() : 11'h7ff;
    total_cnt++; if (e !== {2'b01, 9'h05A}) $display("FAIL stop2_frame_err got %h want %h", e, {2'b01, 9'h05A}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_parity();
    test_frame_err();
    test_break();
    test_overrun();
    test_glitch_reset();
    test_stop2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout reached after %0d cycles", cyc);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Configurable UART receiver, the parametrised successor to the fixed 8N1 receiver in rtl/lib. Adds:
- data width, parity and stop-bit count as parameters;
- parity, framing and break detection;
- a ready/valid output holding register with overrun reporting.
It sits between the board RX pin and byte-stream consumers (command parser, FIFO).

Parameters:
CLOCKS_PER_BAUD, 6, clocks per bit period; minimum 4.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_i  in  1  raw serial input, asynchronous to clock; idles high
data_o  out  DATA_BITS  received data, LSB first on the wire
valid_o  out  1  data_o and the error flags are valid
ready_i  in  1  consumer accepts data when valid_o && ready_i
parity_err_o  out  1  parity mismatch for the held frame; qualified by valid_o
frame_err_o  out  1  a stop bit sampled low for the held frame; qualified by valid_o
overrun_o  out  1  one-cycle pulse: a completed frame was dropped
break_o  out  1  one-cycle pulse: break condition detected

Behaviour:
- Reset (reset low, asynchronous): state IDLE.
  - valid_o, parity_err_o, frame_err_o, overrun_o, break_o all 0.
  - data_o 0; counters 0.
- rx_i passes through a sync2ff two-flop synchronizer; "rx" below means the synchronized signal (2-cycle latency).
- Counter rules:
  - baud counter width is $clog2(CLOCKS_PER_BAUD) bits.
  - HALF = CLOCKS_PER_BAUD/2 - 1; FULL = CLOCKS_PER_BAUD - 1.
  - "Sample" means the cycle in which the counter is 0 in that state; otherwise the counter decrements.
- State machine:
  - IDLE: rx==0 -> START, counter <= HALF.
  - START: at sample, rx==1 -> IDLE (false start, no output). rx==0 -> DATA, counter <= FULL, bit index 0.
  - DATA: at each sample, shift rx into the shift register MSB side, LSB-first order. After DATA_BITS samples -> PARITY if PARITY!=0, else STOP. Counter <= FULL on every sample.
  - PARITY: at sample, parity_bad = (XOR of data bits XOR rx) != (PARITY==1 ? 1 : 0). Then -> STOP, counter <= FULL.
  - STOP: sample STOP_BITS times, FULL apart. A low sample on any stop bit sets frame_bad.
  - At the final stop sample:
    - break = frame_bad AND all data bits 0 AND (PARITY==0 OR parity bit 0).
    - break: pulse break_o next cycle; deliver nothing; -> WAIT_HIGH.
    - otherwise: deliver the frame; -> IDLE if rx==1, else -> WAIT_HIGH.
  - WAIT_HIGH: remain until rx==1, then -> IDLE. Prevents a low line re-triggering a start.
  - Undefined state encodings -> IDLE.
- Delivery (the cycle after the final stop sample):
  - If valid_o==0, or valid_o && ready_i in that same cycle: load data_o, parity_err_o and frame_err_o, and set valid_o=1. The new frame wins; the old one counts as consumed.
  - Else: keep the held frame unchanged, pulse overrun_o for 1 cycle, drop the new frame.
- Handshake:
  - valid_o clears the cycle after valid_o && ready_i, unless a delivery loads in that same cycle.
  - data_o and the error flags stay stable while valid_o is high.
- Latency: valid_o rises 1 cycle after the final stop-bit sample, i.e. mid final stop bit.
- Reception continues regardless of ready_i; backpressure never stalls the state machine.
- A 9-bit DATA_BITS frame is held entirely in data_o. There is no separate 9th-bit port.

Test Plan:
- CPB=6, 8N1, send 0xA5 then 0x3C with ready_i=1 -> two valid_o pulses, data_o=0xA5 then 0x3C, no error flags; valid_o rises 1 cycle after the stop sample.
- DATA_BITS=7, PARITY=2: send 0x41 with parity bit 0, then with parity bit 1 -> parity_err_o=0 then 1, data_o=0x41 both times.
- 8N1, send 0x55 with the stop bit forced low, then rx high -> valid_o with frame_err_o=1, data_o=0x55; next frame 0x12 received cleanly.
- 8N1, hold rx low for 20 bit times, then release -> single break_o pulse, no valid_o, no false start until rx returns high; following 0x7E received correctly.
- ready_i=0, send 0x11 then 0x22 -> valid_o stays high, data_o=0x11, overrun_o pulses once at the 0x22 delivery; raise ready_i -> valid_o falls.
- Low glitch of 2 clocks on rx_i, plus reset asserted mid-DATA -> no valid_o, outputs 0 immediately on reset; after release, 0xC3 received correctly. Also run STOP_BITS=2 with second stop bit low -> frame_err_o=1.
